// File: rtl/poly_voice_mixer.sv
// Polyphonic voice allocator (retrigger, free slot, oldest steal) with a two-stage sample mixer.
// Define MIX_AUTOGAIN_EN to scale the mix by the active voice count and saturate it.
module poly_voice_mixer #(
    parameter int NUM_VOICES   = 4,
    parameter int SAMPLE_WIDTH = 8,
    parameter int RATE_WIDTH   = 24,
    parameter int AGE_WIDTH    = 4
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             evt_valid_in,
    output logic                             evt_ready_out,
    input  logic                             evt_note_on_in,
    input  logic [6:0]                       evt_note_in,
    input  logic [RATE_WIDTH-1:0]            evt_rate_in,
    input  logic                             all_off_in,
    output logic [NUM_VOICES-1:0]            voice_on_out,
    output logic [NUM_VOICES*RATE_WIDTH-1:0] voice_rate_out,
    input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_sample_in,
    output logic [$clog2(NUM_VOICES):0]      active_cnt_out,
    output logic [SAMPLE_WIDTH-1:0]          mix_out
);
    localparam int IW   = $clog2(NUM_VOICES);
    localparam int CW   = IW + 1;
    localparam int SUMW = SAMPLE_WIDTH + IW;

    // Event handshake: an event transfers on a clock edge where evt_valid_in && evt_ready_out;
    // evt_ready_out is high only while idle, so at most one event is in flight.
    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
    state_t state, state_next;

    logic                  accept;
    logic [IW-1:0]         scan_idx;
    logic                  ev_on;
    logic [6:0]            ev_note;
    logic [RATE_WIDTH-1:0] ev_rate;

    logic [NUM_VOICES-1:0] voice_on;
    logic [6:0]            note [NUM_VOICES];
    logic [RATE_WIDTH-1:0] rate [NUM_VOICES];
    logic [AGE_WIDTH-1:0]  age  [NUM_VOICES];

    logic                  match_found, free_found, old_found;
    logic [IW-1:0]         match_idx, free_idx, old_idx, tgt;
    logic [AGE_WIDTH-1:0]  old_age;

    always_comb begin
        state_next    = state;
        evt_ready_out = 1'b0;
        case (state)
            IDLE: begin
                evt_ready_out = 1'b1;
                if (evt_valid_in) state_next = SCAN;
            end
            SCAN:    if (scan_idx == IW'(NUM_VOICES - 1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign accept = evt_valid_in && evt_ready_out;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= IDLE;
            scan_idx <= '0;
            ev_on    <= 1'b0;
            ev_note  <= '0;
            ev_rate  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                scan_idx <= '0;
                ev_on    <= evt_note_on_in;
                ev_note  <= evt_note_in;
                ev_rate  <= evt_rate_in;
            end else if (state == SCAN) begin
                scan_idx <= scan_idx + 1'b1;
            end
        end
    end

    // One voice per SCAN cycle. A panic during the scan leaves every voice examined so far free.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            old_age     <= '0;
        end else if (accept) begin
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
        end else if (state == SCAN) begin
            if (all_off_in) begin
                match_found <= 1'b0;
                old_found   <= 1'b0;
                free_found  <= 1'b1;
                free_idx    <= '0;
            end else if (voice_on[scan_idx]) begin
                if (!match_found && note[scan_idx] == ev_note) begin
                    match_found <= 1'b1;
                    match_idx   <= scan_idx;
                end
                if (!old_found || age[scan_idx] > old_age) begin
                    old_found <= 1'b1;
                    old_idx   <= scan_idx;
                    old_age   <= age[scan_idx];
                end
            end else if (!free_found) begin
                free_found <= 1'b1;
                free_idx   <= scan_idx;
            end
        end
    end

    always_comb begin
        tgt = old_idx;
        if (free_found)  tgt = free_idx;
        if (match_found) tgt = match_idx;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            voice_on <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note[i] <= '0;
                rate[i] <= '0;
                age[i]  <= '0;
            end
        end else if (all_off_in) begin
            voice_on <= '0;
            for (int i = 0; i < NUM_VOICES; i++) age[i] <= '0;
        end else if (state == COMMIT) begin
            if (ev_on) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (IW'(i) == tgt) begin
                        voice_on[i] <= 1'b1;
                        note[i]     <= ev_note;
                        rate[i]     <= ev_rate;
                        age[i]      <= '0;
                    end else if (voice_on[i] && age[i] != '1) begin
                        age[i] <= age[i] + 1'b1;
                    end
                end
            end else if (match_found) begin
                voice_on[match_idx] <= 1'b0;
                age[match_idx]      <= '0;
            end
        end
    end

    assign voice_on_out = voice_on;
    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_rate
        assign voice_rate_out[g*RATE_WIDTH +: RATE_WIDTH] = rate[g];
    end

    logic [CW-1:0]          cnt_next;
    logic signed [SUMW-1:0] sum_next, sum_r;

    always_comb begin
        cnt_next = '0;
        sum_next = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            cnt_next = cnt_next + CW'(voice_on[i]);
            if (voice_on[i])
                sum_next = sum_next + SUMW'($signed(voice_sample_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]));
        end
    end

`ifdef MIX_AUTOGAIN_EN
    localparam logic signed [SUMW-1:0] MAX_V = {{(IW+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [SUMW-1:0] MIN_V = {{(IW+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};
    logic [CW-1:0]          gain_shift;
    logic signed [SUMW-1:0] scaled;
    logic [SAMPLE_WIDTH-1:0] mix_next;

    // Shift is ceil(log2(count)); the count is registered alongside sum_r, so both describe the same voices.
    always_comb begin
        gain_shift = '0;
        for (int k = 0; k < IW; k++)
            if ((CW'(1) << k) < active_cnt_out) gain_shift = CW'(k + 1);
        scaled = sum_r >>> gain_shift;
        if (scaled > MAX_V)      mix_next = MAX_V[SAMPLE_WIDTH-1:0];
        else if (scaled < MIN_V) mix_next = MIN_V[SAMPLE_WIDTH-1:0];
        else                     mix_next = scaled[SAMPLE_WIDTH-1:0];
    end
`else
    logic signed [SUMW-1:0]  scaled;
    logic [SAMPLE_WIDTH-1:0] mix_next;

    always_comb begin
        scaled   = sum_r >>> IW;
        mix_next = scaled[SAMPLE_WIDTH-1:0];
    end
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            active_cnt_out <= '0;
            sum_r          <= '0;
            mix_out        <= '0;
        end else begin
            active_cnt_out <= cnt_next;
            sum_r          <= sum_next;
            mix_out        <= mix_next;
        end
    end
endmodule

// File: tb/tb_poly_voice_mixer.sv
// Randomised and directed checks of poly_voice_mixer against an array-based allocation and mix model.
module tb_poly_voice_mixer;
    localparam int NV = 4;
    localparam int SW = 8;
    localparam int RW = 24;
    localparam int AGE_MAX = 15;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             evt_valid_in;
    logic             evt_ready_out;
    logic             evt_note_on_in;
    logic [6:0]       evt_note_in;
    logic [RW-1:0]    evt_rate_in;
    logic             all_off_in;
    logic [NV-1:0]    voice_on_out;
    logic [NV*RW-1:0] voice_rate_out;
    logic [NV*SW-1:0] voice_sample_in;
    logic [2:0]       active_cnt_out;
    logic [SW-1:0]    mix_out;

    always #5 clk_in = ~clk_in;

    poly_voice_mixer dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .evt_valid_in(evt_valid_in), .evt_ready_out(evt_ready_out),
        .evt_note_on_in(evt_note_on_in), .evt_note_in(evt_note_in), .evt_rate_in(evt_rate_in),
        .all_off_in(all_off_in), .voice_on_out(voice_on_out), .voice_rate_out(voice_rate_out),
        .voice_sample_in(voice_sample_in), .active_cnt_out(active_cnt_out), .mix_out(mix_out)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    bit m_on   [NV];
    int m_note [NV];
    int m_rate [NV];
    int m_age  [NV];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [NV-1:0] model_vec();
        logic [NV-1:0] v = '0;
        for (int i = 0; i < NV; i++) v[i] = m_on[i];
        return v;
    endfunction

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < NV; i++) c += m_on[i];
        return c;
    endfunction

    function automatic logic [RW-1:0] rate_of(input int i);
        return voice_rate_out[i*RW +: RW];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NV; i++) begin
            m_on[i]  = 1'b0;
            m_age[i] = 0;
        end
    endtask

    task automatic model_event(input bit on, input int nt, input int rt);
        int hit = -1, free = -1, old = -1, tgt;
        for (int i = 0; i < NV; i++) begin
            if (m_on[i] && m_note[i] == nt && hit < 0) hit = i;
            if (!m_on[i] && free < 0) free = i;
            if (m_on[i] && (old < 0 || m_age[i] > m_age[old])) old = i;
        end
        if (on) begin
            tgt = (hit >= 0) ? hit : (free >= 0) ? free : old;
            for (int i = 0; i < NV; i++)
                if (i != tgt && m_on[i] && m_age[i] < AGE_MAX) m_age[i]++;
            m_on[tgt] = 1'b1;
            m_note[tgt] = nt;
            m_rate[tgt] = rt;
            m_age[tgt] = 0;
        end else if (hit >= 0) begin
            m_on[hit] = 1'b0;
            m_age[hit] = 0;
        end
    endtask

    function automatic logic [SW-1:0] model_mix();
        int sum = 0, s = 0, cnt, r;
        logic [SW-1:0] b;
        cnt = model_cnt();
        for (int i = 0; i < NV; i++) begin
            b = voice_sample_in[i*SW +: SW];
            if (m_on[i]) sum += int'($signed(b));
        end
`ifdef MIX_AUTOGAIN_EN
        while ((1 << s) < cnt) s++;
        r = sum >>> s;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
`else
        s = 2;
        r = sum >>> s;
`endif
        return r[SW-1:0];
    endfunction

    task automatic check_voices(input string tag);
        check({tag, "_on"}, voice_on_out, model_vec());
        for (int i = 0; i < NV; i++)
            if (m_on[i]) check($sformatf("%s_rate%0d", tag, i), rate_of(i), m_rate[i]);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        evt_valid_in = 1'b0;
        all_off_in = 1'b0;
        repeat (2) @(negedge clk_in);
        model_clear();
        rst_in = 1'b1;
    endtask

    task automatic send_event(input bit on, input int nt, input int rt, input bit panic);
        logic [NV-1:0] prev;
        int k = 0, lat = 0;
        @(negedge clk_in);
        evt_valid_in = 1'b1;
        evt_note_on_in = on;
        evt_note_in = nt[6:0];
        evt_rate_in = rt[RW-1:0];
        while (!evt_ready_out && k < 20) begin
            @(negedge clk_in);
            k++;
        end
        if (!evt_ready_out) begin
            check("accept_timeout", 0, 1);
            evt_valid_in = 1'b0;
            return;
        end
        @(posedge clk_in);
        @(negedge clk_in);
        evt_valid_in = 1'b0;
        prev = model_vec();
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_in);
            if (c == 4) begin
                check("pre_commit_on", voice_on_out, prev);
                check("pre_commit_rdy", evt_ready_out, 0);
                if (panic) all_off_in = 1'b1;
            end
            if (c == 5) all_off_in = 1'b0;
            if (evt_ready_out) begin
                lat = c;
                break;
            end
        end
        all_off_in = 1'b0;
        check("ready_latency", lat, 5);
        if (panic) model_clear();
        else model_event(on, nt, rt);
        check_voices("post");
        @(negedge clk_in);
        check("active_cnt", active_cnt_out, model_cnt());
    endtask

    task automatic mix_check(input string tag);
        exp_q.push_back(32'(model_mix()));
        repeat (2) @(negedge clk_in);
        check(tag, mix_out, exp_q.pop_front());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_in = 1'b0;
        evt_valid_in = 1'b0;
        evt_note_on_in = 1'b0;
        evt_note_in = '0;
        evt_rate_in = '0;
        all_off_in = 1'b0;
        voice_sample_in = '0;
        model_clear();
        for (int i = 0; i < NV; i++) begin
            m_note[i] = 0;
            m_rate[i] = 0;
        end
        do_reset();
        check("rst_ready", evt_ready_out, 1);
        check("rst_on", voice_on_out, 0);
        check("rst_rates", voice_rate_out == '0, 1);
        check("rst_cnt", active_cnt_out, 0);
        check("rst_mix", mix_out, 0);

        send_event(1, 60, 100, 0);
        send_event(1, 62, 200, 0);
        send_event(1, 64, 300, 0);
        check("alloc_on", voice_on_out, 4'b0111);
        check("alloc_r0", rate_of(0), 100);
        check("alloc_r1", rate_of(1), 200);
        check("alloc_r2", rate_of(2), 300);
        send_event(1, 62, 250, 0);
        check("retrig_on", voice_on_out, 4'b0111);
        check("retrig_r1", rate_of(1), 250);
        check("retrig_r0", rate_of(0), 100);

        send_event(1, 65, 400, 0);
        send_event(1, 67, 500, 0);
        check("steal_on", voice_on_out, 4'b1111);
        check("steal_r0", rate_of(0), 500);
        check("steal_r3", rate_of(3), 400);

        send_event(0, 62, 0, 0);
        check("off_on", voice_on_out, 4'b1101);
        send_event(0, 70, 0, 0);
        check("off_miss_on", voice_on_out, 4'b1101);
        send_event(1, 69, 600, 0);
        check("reuse_on", voice_on_out, 4'b1111);
        check("reuse_r1", rate_of(1), 600);

        do_reset();
        send_event(1, 60, 10, 0);
        send_event(1, 62, 20, 0);
        @(negedge clk_in);
        voice_sample_in = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'd60, 8'd100};
        mix_check("mix_two_model");
`ifdef MIX_AUTOGAIN_EN
        check("mix_two", mix_out, 80);
`else
        check("mix_two", mix_out, 40);
`endif
        send_event(1, 64, 30, 0);
        send_event(1, 65, 40, 0);
        @(negedge clk_in);
        voice_sample_in = {4{8'd127}};
        mix_check("mix_four_model");
        check("mix_four", mix_out, 127);

        @(negedge clk_in);
        evt_valid_in = 1'b1;
        evt_note_on_in = 1'b1;
        evt_note_in = 7'd60;
        evt_rate_in = 24'd99;
        @(posedge clk_in);
        @(negedge clk_in);
        evt_valid_in = 1'b0;
        @(negedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        check("scanrst_on", voice_on_out, 0);
        check("scanrst_ready", evt_ready_out, 1);
        check("scanrst_mix", mix_out, 0);
        @(negedge clk_in);
        model_clear();
        rst_in = 1'b1;
        send_event(1, 61, 11, 0);
        check("scanrst_alloc", voice_on_out, 4'b0001);
        check("scanrst_rate", rate_of(0), 11);

        send_event(1, 63, 22, 0);
        send_event(1, 60, 77, 1);
        check("panic_on", voice_on_out, 0);
        check("panic_cnt", active_cnt_out, 0);
        check("panic_ready", evt_ready_out, 1);

        for (int it = 0; it < 80; it++) begin
            send_event($urandom_range(0, 9) < 7, 60 + $urandom_range(0, 7),
                       $urandom_range(1, 16777215), $urandom_range(0, 15) == 0);
            @(negedge clk_in);
            voice_sample_in = NV*SW'($urandom());
            mix_check("mix_rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
